// File: rtl/mult_div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mult_div_sequencer_pkg
//  Desc   : Shared operation and state encodings for the iterative HI/LO
//           multiply/divide unit, plus small decode helpers.
//  Rev    : 1.0  initial release
// ============================================================================
package mult_div_sequencer_pkg;

  // Operation select driven by the main control FSM (from funct).
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_PREP = 2'b01,
    MD_CALC = 2'b10,
    MD_FIX  = 2'b11
  } md_state_e;

  function automatic logic md_is_signed(md_op_e o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

  function automatic logic md_is_div(md_op_e o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_sequencer_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module : md_sign_fix
//  Desc   : Combinational conditional two's-complement negate.
//  Ports  : din  [W-1:0] in   value to condition
//           neg          in   1 = output -din, 0 = output din
//           dout [W-1:0] out  result
//  Rev    : 1.0  initial release
// ============================================================================
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule
`default_nettype wire

// File: rtl/mult_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : mult_div_sequencer
//  Desc   : Iterative radix-2 HI/LO unit for MULT/MULTU/DIV/DIVU. Owns the
//           HI and LO registers. One shift-add (multiply) or restoring
//           subtract (divide) step per cycle, N steps per operation.
//  Ports  : clk       in        rising-edge clock
//           rst       in        asynchronous active-low reset
//           start     in        operation request (accepted only when idle)
//           op        in  [1:0] operation select, sampled with start
//           a         in  [N-1] rs operand, sampled with start
//           b         in  [N-1] rt operand, sampled with start
//           cancel    in        abort an in-flight operation
//           mthi_we   in        write wdata to HI (idle only)
//           mtlo_we   in        write wdata to LO (idle only)
//           wdata     in  [N-1] MTHI/MTLO data
//           busy      out       operation in flight
//           done      out       one-cycle pulse, hi/lo carry the new result
//           hi        out [N-1] HI register
//           lo        out [N-1] LO register
//  Rev    : 1.0  initial release
// ============================================================================
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cancel,
  input  logic         mthi_we,
  input  logic         mtlo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(N - 1);

  md_state_e        r_state;
  md_state_e        w_next;
  md_op_e           r_op;
  logic [N-1:0]     r_acc;      // partial product high half / running remainder
  logic [N-1:0]     r_q;        // operand a, then product low half / quotient
  logic [N-1:0]     r_b;        // operand b, then |b|
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_res;  // negate product / quotient at the end
  logic             r_neg_rem;  // negate remainder at the end
  logic             r_dbz;
  logic [N-1:0]     r_hi;
  logic [N-1:0]     r_lo;
  logic             r_done;

  logic             w_signed;
  logic             w_is_div;
  logic             w_dbz;
  logic             w_prep;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != MD_IDLE);
    case (r_state)
      MD_IDLE: if (start) w_next = MD_PREP;
      MD_PREP: w_next = w_dbz ? MD_FIX : MD_CALC;
      MD_CALC: if (r_cnt == C_LAST_CNT) w_next = MD_FIX;
      MD_FIX:  w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
    // Abort takes priority over every busy transition, including the final
    // FIX edge, so a flushed instruction never touches HI/LO.
    if (cancel && (r_state != MD_IDLE)) w_next = MD_IDLE;
  end

  // --------------------------------------------------------------------------
  // Sign conditioning. The two N-wide negators take |a|,|b| in PREP and
  // correct quotient/remainder in FIX; the 2N-wide one corrects the product.
  // --------------------------------------------------------------------------
  assign w_signed = md_is_signed(r_op);
  assign w_is_div = md_is_div(r_op);
  assign w_dbz    = w_is_div && (r_b == '0);
  assign w_prep   = (r_state == MD_PREP);

  logic [N-1:0]   w_fix_lo_out;
  logic [N-1:0]   w_fix_hi_in;
  logic [N-1:0]   w_fix_hi_out;
  logic           w_fix_lo_neg;
  logic           w_fix_hi_neg;
  logic [2*N-1:0] w_prod_out;

  assign w_fix_lo_neg = w_prep ? (w_signed & r_q[N-1]) : r_neg_res;
  assign w_fix_hi_in  = w_prep ? r_b : r_acc;
  assign w_fix_hi_neg = w_prep ? (w_signed & r_b[N-1]) : r_neg_rem;

  md_sign_fix #(.W(N)) u_fix_lo (
    .din  (r_q),
    .neg  (w_fix_lo_neg),
    .dout (w_fix_lo_out)
  );

  md_sign_fix #(.W(N)) u_fix_hi (
    .din  (w_fix_hi_in),
    .neg  (w_fix_hi_neg),
    .dout (w_fix_hi_out)
  );

  md_sign_fix #(.W(2*N)) u_fix_prod (
    .din  ({r_acc, r_q}),
    .neg  (r_neg_res),
    .dout (w_prod_out)
  );

  // --------------------------------------------------------------------------
  // Iteration step
  // --------------------------------------------------------------------------
  // Multiply: add |b| when the current multiplier LSB is set, then shift the
  // {acc,q} pair right; the carry lands in the top of acc.
  logic [N:0] w_add;
  assign w_add = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(N+1){1'b0}});

  // Divide: shift the next dividend bit into the remainder and try to
  // subtract. The remainder is always below |b|, so N+1 bits suffice and the
  // top bit of the difference is the borrow.
  logic [N:0] w_shift;
  logic [N:0] w_diff;
  logic       w_qbit;
  assign w_shift = {r_acc, r_q[N-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_qbit  = ~w_diff[N];

  // --------------------------------------------------------------------------
  // Datapath and architectural registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op      <= MD_MULT;
      r_acc     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (mthi_we) r_hi <= wdata;
          if (mtlo_we) r_lo <= wdata;
          if (start) begin
            r_op <= md_op_e'(op);
            r_q  <= a;
            r_b  <= b;
          end
        end
        MD_PREP: begin
          r_acc     <= '0;
          r_cnt     <= '0;
          r_neg_res <= w_signed & (r_q[N-1] ^ r_b[N-1]);
          r_neg_rem <= w_signed & r_q[N-1];
          r_dbz     <= w_dbz;
          // On divide-by-zero the raw dividend is kept for HI.
          if (!w_dbz) begin
            r_q <= w_fix_lo_out;
            r_b <= w_fix_hi_out;
          end
        end
        MD_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_is_div) begin
            r_acc <= w_qbit ? w_diff[N-1:0] : w_shift[N-1:0];
            r_q   <= {r_q[N-2:0], w_qbit};
          end else begin
            r_acc <= w_add[N:1];
            r_q   <= {w_add[0], r_q[N-1:1]};
          end
        end
        MD_FIX: begin
          if (!cancel) begin
            r_done <= 1'b1;
            if (r_dbz) begin
              r_hi <= r_q;
              r_lo <= '1;
            end else if (w_is_div) begin
              r_hi <= w_fix_hi_out;
              r_lo <= w_fix_lo_out;
            end else begin
              r_hi <= w_prod_out[2*N-1:N];
              r_lo <= w_prod_out[N-1:0];
            end
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : tb_mult_div_sequencer
//  Desc   : Scoreboard bench for mult_div_sequencer. Stimulus pushes expected
//           {hi,lo} and completion cycle; a monitor pops on every done pulse.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_mult_div_sequencer;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cancel;
  logic         mthi_we;
  logic         mtlo_we;
  logic [N-1:0] wdata;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_done = 0;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sbq[$];

  mult_div_sequencer #(.N(N), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .cancel  (cancel),
    .mthi_we (mthi_we),
    .mtlo_we (mtlo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: plain 64-bit arithmetic. Returns {hi, lo}.
  function automatic logic [63:0] model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = sx * sy; return p; end
      2'b01: return {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_done++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual hi=%h lo=%h required no done", hi, lo);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_done_cycle"}, cyc, e.cyc);
        chk({e.name, "_busy_at_done"}, busy, 0);
      end
    end
  end

  // Called at a negedge: drive start for one cycle. The next posedge is the
  // start edge; done is seen 34 edges later (2 on divide-by-zero).
  task automatic issue(logic [1:0] o, logic [31:0] x, logic [31:0] y, bit push,
                       logic [63:0] req, string name);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      e.hi   = req[63:32];
      e.lo   = req[31:0];
      e.cyc  = cyc + 1 + ((o[1] && (y == 0)) ? 2 : 34);
      e.name = name;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_timeout actual=pending required=complete", name);
      sbq.delete();
    end
  endtask

  task automatic idle_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] hold_hi, x, y;
    logic [1:0]  o;
    int          d0;
    bit          busy_ok;

    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    cancel = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
    idle_cycles(3);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    rst = 1'b1;
    idle_cycles(2);

    // MULT with busy held through the whole operation.
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 1, 64'hFFFF_FFFF_FFFF_FFEB, "mult_7_m3");
    busy_ok = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (!busy) busy_ok = 1'b0;
      if (i < 32) @(negedge clk);
    end
    chk("mult_busy_window", busy_ok, 1);
    drain("mult_7_m3");

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, "multu_max");
    drain("multu_max");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
    drain("div_m7_2");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0000_0000_8000_0000, "div_ovf");
    drain("div_ovf");
    issue(2'b11, 32'h64, 32'd0, 1, 64'h0000_0064_FFFF_FFFF, "divu_by0");
    drain("divu_by0");
    issue(2'b10, 32'hFFFF_FF00, 32'd0, 1, 64'hFFFF_FF00_FFFF_FFFF, "div_by0");
    drain("div_by0");

    // Restart and MTHI while busy are both ignored.
    hold_hi = hi;
    d0 = n_done;
    issue(2'b00, 32'd3, 32'd5, 1, 64'h0000_0000_0000_000F, "mult_restart");
    idle_cycles(3);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd9;
    @(negedge clk);
    start = 1'b0; mthi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi_we = 1'b0;
    chk("mthi_while_busy", hi, hold_hi);
    drain("mult_restart");
    idle_cycles(40);
    chk("restart_single_done", n_done - d0, 1);

    // Reset in the middle of a DIVU.
    d0 = n_done;
    issue(2'b11, 32'h1234_5678, 32'd7, 0, 64'h0, "divu_rst");
    idle_cycles(9);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(40);
    chk("midrst_no_done", n_done - d0, 0);

    // Cancel mid-MULT with preloaded HI/LO.
    mthi_we = 1'b1; wdata = 32'h11;
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h22;
    @(negedge clk);
    mtlo_we = 1'b0;
    chk("mt_preload", {hi, lo}, {32'h11, 32'h22});
    d0 = n_done;
    issue(2'b00, 32'h9999, 32'h7777, 0, 64'h0, "mult_cancel");
    idle_cycles(19);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    idle_cycles(40);
    chk("cancel_hilo", {hi, lo}, {32'h11, 32'h22});
    chk("cancel_no_done", n_done - d0, 0);

    // Cancel coinciding with the FIX edge.
    issue(2'b01, 32'hABCD, 32'h1234, 0, 64'h0, "mult_cancel_fix");
    idle_cycles(33);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_fix_busy", busy, 0);
    idle_cycles(5);
    chk("cancel_fix_hilo", {hi, lo}, {32'h11, 32'h22});
    chk("cancel_fix_no_done", n_done - d0, 0);

    // start + MTHI in the same idle cycle; cancel in idle is ignored.
    mthi_we = 1'b1; cancel = 1'b1; wdata = 32'hABCD_1234;
    issue(2'b11, 32'd1000, 32'd7, 1, {32'd6, 32'd142}, "divu_with_mt");
    mthi_we = 1'b0; cancel = 1'b0;
    chk("mt_with_start_hi", hi, 32'hABCD_1234);
    chk("idle_cancel_ignored", busy, 1);
    drain("divu_with_mt");

    // Randomised operations against the model.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        3: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      issue(o, x, y, 1, model(o, x, y), $sformatf("rand%0d_op%0d", i, o));
      drain("rand");
    end

    idle_cycles(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
